skolem_sweep_ctrl: RTL and testbench

Exhaustive-check sequencer for a combinational or pipelined Skolem-function block with N inputs and N outputs under the mirror specification (output bit k must equal input bit k). On `start` it drives every input assignment 0 … 2^N−1 into the function block and compares each returned output vector against its expected value. It counts mismatches, records the first failing assignment and reports pass/fail. It sits beside the synthesized Skolem netlist in the benchmark test harness. The netlist is untouched: its inputs are wired to `x_out` and its outputs to `y_in`.

---
 rtl/skolem_sweep_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_skolem_sweep_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skolem_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// skolem_sweep_ctrl
//
// Exhaustive checker for a Skolem-function netlist under the mirror
// specification: every input assignment 0 .. 2^N-1 is driven on x_out and the
// returned y_in must equal the assignment that produced it, LAT cycles later.
// Mismatches are counted (saturating at 2^N), the earliest failing assignment
// is captured, and a pass/aborted verdict is held while done is high.
//
// Parameters
//   N    vector width (1..16)
//   LAT  function-block latency from x_out to y_in in cycles (0..7)
//
// Ports
//   clk              clock, rising edge
//   rst              synchronous reset, active high
//   start            begin a sweep (honoured in IDLE / DONE)
//   abort            stop a sweep (honoured in SWEEP / DRAIN)
//   x_out  [N-1:0]   assignment driven into the function block
//   y_in   [N-1:0]   function-block outputs
//   busy             high in SWEEP and DRAIN
//   done             level, high in DONE
//   pass             verdict, valid while done
//   aborted          sweep ended by abort, valid while done
//   mismatch_count   [N:0] failing assignments so far
//   first_fail_valid at least one mismatch recorded
//   first_fail_vec   [N-1:0] earliest failing assignment
// -----------------------------------------------------------------------------
module skolem_sweep_ctrl #(
    parameter int N   = 10,
    parameter int LAT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    output logic [N-1:0] x_out,
    input  logic [N-1:0] y_in,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic         aborted,
    output logic [N:0]   mismatch_count,
    output logic         first_fail_valid,
    output logic [N-1:0] first_fail_vec
);

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

    localparam logic [N-1:0] X_LAST     = '1;
    localparam logic [N:0]   CNT_MAX    = {1'b1, {N{1'b0}}};
    localparam logic [2:0]   DRAIN_LAST = 3'(LAT - 1);

    state_t       state_q;
    logic [N-1:0] x_q;
    logic [2:0]   drain_q;
    logic         busy_q, done_q, pass_q, aborted_q;
    logic [N:0]   cnt_q, cnt_d;
    logic         ffv_q, ffv_d;
    logic [N-1:0] ffvec_q, ffvec_d;

    logic         head_valid;
    logic         flush;
    logic         tail_valid;
    logic [N-1:0] tail_vec;
    logic         mismatch;

    assign head_valid = (state_q == S_SWEEP);
    // An abort throws away every comparison still travelling down the pipe.
    assign flush      = abort && (state_q == S_SWEEP || state_q == S_DRAIN);

    // Expected-value pipeline, kept in lockstep with the function block.
    generate
        if (LAT == 0) begin : g_comb
            assign tail_valid = head_valid;
            assign tail_vec   = x_q;
        end else begin : g_pipe
            logic [LAT-1:0] pv_q;
            logic [N-1:0]   pe_q [LAT];

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    pv_q <= '0;
                    for (int i = 0; i < LAT; i++) pe_q[i] <= '0;
                end else begin
                    pv_q[0] <= head_valid;
                    pe_q[0] <= x_q;
                    for (int i = 1; i < LAT; i++) begin
                        pv_q[i] <= pv_q[i-1];
                        pe_q[i] <= pe_q[i-1];
                    end
                end
            end

            assign tail_valid = pv_q[LAT-1];
            assign tail_vec   = pe_q[LAT-1];
        end
    endgenerate

    // Scoreboard update for the comparison resolving this cycle.
    always_comb begin
        mismatch = tail_valid && (y_in != tail_vec);
        cnt_d    = cnt_q;
        ffv_d    = ffv_q;
        ffvec_d  = ffvec_q;
        if (mismatch) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + (N+1)'(1);
            if (!ffv_q) begin
                ffv_d   = 1'b1;
                ffvec_d = tail_vec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            drain_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            aborted_q <= 1'b0;
            cnt_q     <= '0;
            ffv_q     <= 1'b0;
            ffvec_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q   <= S_SWEEP;
                        x_q       <= '0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                        aborted_q <= 1'b0;
                        cnt_q     <= '0;
                        ffv_q     <= 1'b0;
                        ffvec_q   <= '0;
                    end
                end
                S_SWEEP, S_DRAIN: begin
                    // The comparison resolving this cycle is always retired.
                    cnt_q   <= cnt_d;
                    ffv_q   <= ffv_d;
                    ffvec_q <= ffvec_d;
                    if (abort) begin
                        state_q   <= S_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        pass_q    <= 1'b0;
                        aborted_q <= 1'b1;
                    end else if (state_q == S_SWEEP) begin
                        // Last assignment wraps x to 0 but never starts a new pass.
                        x_q <= x_q + N'(1);
                        if (x_q == X_LAST) begin
                            if (LAT == 0) begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                pass_q  <= (cnt_d == '0);
                            end else begin
                                state_q <= S_DRAIN;
                                drain_q <= '0;
                            end
                        end
                    end else begin
                        if (drain_q == DRAIN_LAST) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (cnt_d == '0);
                        end else begin
                            drain_q <= drain_q + 3'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign x_out            = x_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign aborted          = aborted_q;
    assign mismatch_count   = cnt_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_skolem_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_skolem_sweep_ctrl
//
// Two checkers share one clock: u_lat0 (LAT=0) and u_lat2 (LAT=2), both N=10.
// The stimulus process starts sweeps and pushes the hand-computed verdict of
// each sweep into a queue; the monitor pops an entry whenever a checker raises
// done and compares verdict, counters, done timing, busy length and the x_out
// sequence.
// -----------------------------------------------------------------------------
module tb_skolem_sweep_ctrl;

    localparam int N  = 10;
    localparam int NV = 1 << N;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start0, abort0, start2, abort2;
    logic [N-1:0] x0, y0, x2, y2, ffvec0, ffvec2;
    logic         busy0, done0, pass0, ab0, ffv0;
    logic         busy2, done2, pass2, ab2, ffv2;
    logic [N:0]   cnt0, cnt2;

    // Function-block models. mode0: 0 mirror, 1 flip bit 3 at x=37, 2 bit 0 stuck low.
    // mode2: 1 mirror through two registers, 0 unregistered mirror.
    int           mode0, mode2;
    logic [N-1:0] d1, d2;

    always_comb begin
        y0 = x0;
        if (mode0 == 1 && x0 == 10'd37) y0[3] = ~x0[3];
        if (mode0 == 2) y0[0] = 1'b0;
    end

    always @(posedge clk) begin
        d1 <= x2;
        d2 <= d1;
    end
    assign y2 = (mode2 == 1) ? d2 : x2;

    skolem_sweep_ctrl #(.N(N), .LAT(0)) u_lat0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .x_out(x0), .y_in(y0), .busy(busy0), .done(done0), .pass(pass0),
        .aborted(ab0), .mismatch_count(cnt0), .first_fail_valid(ffv0),
        .first_fail_vec(ffvec0)
    );

    skolem_sweep_ctrl #(.N(N), .LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .x_out(x2), .y_in(y2), .busy(busy2), .done(done2), .pass(pass2),
        .aborted(ab2), .mismatch_count(cnt2), .first_fail_valid(ffv2),
        .first_fail_vec(ffvec2)
    );

    typedef struct {
        int    dut;
        string name;
        bit    pass;
        bit    aborted;
        int    cnt;
        bit    ffv;
        int    ffvec;
        int    done_cyc;
        int    busy_cyc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   start_cyc [2] = '{0, 0};
    int   gen       [2] = '{0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic set_ctl(input int d, input logic s, input logic a);
        if (d == 0) begin start0 = s; abort0 = a; end
        else        begin start2 = s; abort2 = a; end
    endtask

    // Called at a negedge; the following posedge is the start edge.
    task automatic pulse_start(input int d, input bit push, input string nm,
                               input bit ep, input bit ea, input int ec,
                               input bit ef, input int ev, input int edc,
                               input int ebc);
        exp_t e;
        if (push) begin
            e.dut = d; e.name = nm; e.pass = ep; e.aborted = ea; e.cnt = ec;
            e.ffv = ef; e.ffvec = ev; e.done_cyc = edc; e.busy_cyc = ebc;
            q.push_back(e);
        end
        start_cyc[d] = cyc + 1;
        gen[d]++;
        set_ctl(d, 1'b1, 1'b0);
        @(negedge clk);
        set_ctl(d, 1'b0, 1'b0);
    endtask

    task automatic wait_done(input int d, input int budget);
        for (int i = 0; i < budget; i++) begin
            if ((d == 0 ? done0 : done2) == 1'b1) return;
            @(negedge clk);
        end
        tests++;
        fails++;
        $display("[TB] FAIL done_timeout dut%0d: got done=0 after %0d cycles, expected done=1", d, budget);
    endtask

    task automatic wait_x(input int d, input int val, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (int'(d == 0 ? x0 : x2) == val) return;
            @(negedge clk);
        end
        tests++;
        fails++;
        $display("[TB] FAIL x_timeout dut%0d: x_out never reached %0d", d, val);
    endtask

    // Monitor: one verdict check per rising done.
    initial begin : monitor
        bit           prev  [2] = '{1'b0, 1'b0};
        int           seen  [2] = '{0, 0};
        int           bcnt  [2] = '{0, 0};
        bit           xbad  [2] = '{1'b0, 1'b0};
        logic         dn, bz;
        logic [N-1:0] xv;
        exp_t         e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                dn = (d == 0) ? done0 : done2;
                bz = (d == 0) ? busy0 : busy2;
                xv = (d == 0) ? x0 : x2;
                if (seen[d] != gen[d]) begin
                    seen[d] = gen[d];
                    bcnt[d] = 0;
                    xbad[d] = 1'b0;
                end
                if (bz) begin
                    if (bcnt[d] < NV && xv != N'(bcnt[d])) xbad[d] = 1'b1;
                    bcnt[d]++;
                end
                if (dn && !prev[d]) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL unexpected_done dut%0d: got done with no sweep queued", d);
                    end else begin
                        e = q.pop_front();
                        chk({e.name, "_dut"}, d, e.dut);
                        chk({e.name, "_pass"},    (d == 0) ? pass0 : pass2, e.pass);
                        chk({e.name, "_aborted"}, (d == 0) ? ab0 : ab2, e.aborted);
                        chk({e.name, "_count"},   int'((d == 0) ? cnt0 : cnt2), e.cnt);
                        chk({e.name, "_ffvalid"}, (d == 0) ? ffv0 : ffv2, e.ffv);
                        if (e.ffv)
                            chk({e.name, "_ffvec"}, int'((d == 0) ? ffvec0 : ffvec2), e.ffvec);
                        chk({e.name, "_done_cycle"}, cyc - start_cyc[d] + 1, e.done_cyc);
                        chk({e.name, "_busy_cycles"}, bcnt[d], e.busy_cyc);
                        chk({e.name, "_xseq_bad"}, xbad[d], 0);
                        $display("[TB] sweep %s dut%0d: pass=%0d aborted=%0d count=%0d ffv=%0d ffvec=%0d done_cycle=%0d",
                                 e.name, d, (d == 0) ? pass0 : pass2, (d == 0) ? ab0 : ab2,
                                 (d == 0) ? cnt0 : cnt2, (d == 0) ? ffv0 : ffv2,
                                 (d == 0) ? ffvec0 : ffvec2, cyc - start_cyc[d] + 1);
                    end
                end
                prev[d] = dn;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst = 1'b1;
        start0 = 1'b0; abort0 = 1'b0; start2 = 1'b0; abort2 = 1'b0;
        mode0 = 0; mode2 = 1;
        repeat (3) @(negedge clk);
        chk("reset_x0", int'(x0), 0);
        chk("reset_busy0", busy0, 0);
        chk("reset_done0", done0, 0);
        chk("reset_count0", int'(cnt0), 0);
        chk("reset_ffv0", ffv0, 0);
        chk("reset_done2", done2, 0);
        chk("reset_pass2", pass2, 0);
        $display("[TB] reset checked");
        rst = 1'b0;
        @(negedge clk);

        // Correct mirror, LAT=0.
        mode0 = 0;
        pulse_start(0, 1, "mirror", 1, 0, 0, 0, 0, NV + 1, NV);
        wait_done(0, NV + 20);
        @(negedge clk);

        // Single fault at x=37, started from DONE.
        mode0 = 1;
        pulse_start(0, 1, "single_fault", 0, 0, 1, 1, 37, NV + 1, NV);
        wait_done(0, NV + 20);
        @(negedge clk);

        // Stuck bit 0; counters must restart from zero.
        mode0 = 2;
        pulse_start(0, 1, "stuck_bit0", 0, 0, NV / 2, 1, 1, NV + 1, NV);
        chk("restart_count_clear", int'(cnt0), 0);
        chk("restart_ffv_clear", ffv0, 0);
        chk("restart_done_clear", done0, 0);
        chk("restart_busy", busy0, 1);
        wait_done(0, NV + 20);
        @(negedge clk);

        // Abort while DONE is ignored.
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        chk("abort_in_done_done", done0, 1);
        chk("abort_in_done_aborted", ab0, 0);
        chk("abort_in_done_count", int'(cnt0), NV / 2);
        $display("[TB] abort in DONE checked");

        // Reset mid-sweep.
        mode0 = 2;
        pulse_start(0, 0, "reset_victim", 0, 0, 0, 0, 0, 0, 0);
        wait_x(0, 500, NV);
        chk("pre_reset_count", int'(cnt0), 250);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_x", int'(x0), 0);
        chk("midreset_busy", busy0, 0);
        chk("midreset_done", done0, 0);
        chk("midreset_pass", pass0, 0);
        chk("midreset_aborted", ab0, 0);
        chk("midreset_count", int'(cnt0), 0);
        chk("midreset_ffv", ffv0, 0);
        chk("midreset_ffvec", int'(ffvec0), 0);
        $display("[TB] mid-sweep reset checked");
        @(negedge clk);
        chk("idle_x_hold", int'(x0), 0);
        mode0 = 0;
        pulse_start(0, 1, "after_reset", 1, 0, 0, 0, 0, NV + 1, NV);
        wait_done(0, NV + 20);
        @(negedge clk);

        // start during SWEEP is ignored.
        pulse_start(0, 1, "start_ignored", 1, 0, 0, 0, 0, NV + 1, NV);
        wait_x(0, 200, NV);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done(0, NV + 20);
        @(negedge clk);

        // abort + start together at x=300.
        pulse_start(0, 1, "abort_start", 0, 1, 0, 0, 0, 302, 301);
        wait_x(0, 300, NV);
        start0 = 1'b1; abort0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; abort0 = 1'b0;
        wait_done(0, 10);
        @(negedge clk);

        // Pipelined block, LAT=2, proper two-register mirror.
        mode2 = 1;
        pulse_start(1, 1, "pipe_mirror", 1, 0, 0, 0, 0, NV + 3, NV + 2);
        wait_done(1, NV + 20);
        @(negedge clk);

        // LAT=2 checker against an unregistered mirror.
        mode2 = 0;
        pulse_start(1, 1, "pipe_unreg", 0, 0, NV, 1, 0, NV + 3, NV + 2);
        wait_done(1, NV + 20);
        @(negedge clk);

        // Abort in the first DRAIN cycle.
        mode2 = 1;
        pulse_start(1, 1, "drain_abort", 0, 1, 0, 0, 0, NV + 2, NV + 1);
        repeat (NV) @(negedge clk);
        chk("drain_busy", busy2, 1);
        abort2 = 1'b1;
        @(negedge clk);
        abort2 = 1'b0;
        wait_done(1, 10);
        repeat (3) @(negedge clk);

        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
